// File: rtl/fp_seq_pkg.sv
// rtl/fp_seq_pkg.sv - shared types and helpers for the FP32 adder sequencer
// Purpose: FSM state encoding, FP32 field widths and zero-detection helpers
//          used by fp_add_sequencer and its FIFO.
// Ports:   none (package)
package fp_seq_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int FP_W   = SIGN_W + EXP_W + MANT_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2
  } seq_state_t;

  // +0 and -0 both have a zero exponent and a zero mantissa.
  function automatic logic is_zero(input logic [FP_W-1:0] x);
    return x[EXP_W+MANT_W-1:0] == '0;
  endfunction

  // Sum when at least one operand is zero: the other operand passes through.
  // Two zeros only give -0 when both are -0.
  function automatic logic [FP_W-1:0] zero_sum(input logic [FP_W-1:0] a,
                                               input logic [FP_W-1:0] b);
    if (is_zero(a) && is_zero(b))
      return {a[FP_W-1] & b[FP_W-1], {(FP_W-1){1'b0}}};
    else if (is_zero(a))
      return b;
    else
      return a;
  endfunction

endpackage

// File: rtl/fp_seq_fifo.sv
// rtl/fp_seq_fifo.sv - operand-pair FIFO with occupancy count
// Purpose: DEPTH x W synchronous FIFO, wrap-around pointers, show-ahead read.
// Ports:   clk, reset (async, active-low)
//          push/wdata : write side, ignored when full
//          pop/rdata  : read side, rdata is the current head, pop ignored when empty
//          count/full/empty : occupancy status
module fp_seq_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 64,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fp_add_sequencer.sv
// rtl/fp_add_sequencer.sv - FIFO-buffered issue sequencer for the FP32 adder
// Purpose: buffers operand pairs, runs one adder transaction at a time over the
//          load / result_ready / result_ack handshake, and presents each sum in a
//          valid/ready output register.
// Ports:   clk, reset (async, active-low)
//          in_valid/in_ready/in_a/in_b       : operand-pair input stream
//          out_valid/out_ready/out_sum       : result output stream
//          add_load/add_a/add_b/add_ack      : to the adder
//          add_result/add_ready              : from the adder
//          fifo_count, busy                  : status
// Config:  FP_SEQ_ZERO_BYPASS_EN - pairs with a +/-0 operand skip the adder.
module fp_add_sequencer
  import fp_seq_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_a,
  input  logic [31:0]   in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_sum,
  output logic          add_load,
  output logic [31:0]   add_a,
  output logic [31:0]   add_b,
  input  logic [31:0]   add_result,
  input  logic          add_ready,
  output logic          add_ack,
  output logic [CW-1:0] fifo_count,
  output logic          busy
);

`ifdef FP_SEQ_ZERO_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  seq_state_t  state, state_nxt;
  logic [63:0] head;
  logic [31:0] head_a, head_b;
  logic        fifo_full, fifo_empty;
  logic        pop;
  logic        slot_free;
  logic        head_zero;

  logic        load_nxt, ack_nxt, valid_nxt;
  logic [31:0] a_nxt, b_nxt, sum_nxt;

  fp_seq_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid),
    .wdata ({in_a, in_b}),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_a    = head[63:32];
  assign head_b    = head[31:0];
  assign in_ready  = !fifo_full;
  assign busy      = (state != ST_IDLE) || !fifo_empty;
  // The output register can take a new sum if empty or being drained this cycle.
  assign slot_free = !out_valid || out_ready;
  assign head_zero = BYPASS_EN && (is_zero(head_a) || is_zero(head_b));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (!fifo_empty && !head_zero) state_nxt = ST_WAIT;
      ST_WAIT:    if (add_ready && slot_free)    state_nxt = ST_RELEASE;
      ST_RELEASE: if (!add_ready)                state_nxt = ST_IDLE;
      default:                                   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pop       = 1'b0;
    load_nxt  = add_load;
    ack_nxt   = 1'b0;
    a_nxt     = add_a;
    b_nxt     = add_b;
    sum_nxt   = out_sum;
    valid_nxt = out_valid && !out_ready;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (head_zero) begin
            // Bypassed pairs still respect the output slot, so order is kept.
            if (slot_free) begin
              pop       = 1'b1;
              sum_nxt   = zero_sum(head_a, head_b);
              valid_nxt = 1'b1;
            end
          end else begin
            pop      = 1'b1;
            a_nxt    = head_a;
            b_nxt    = head_b;
            load_nxt = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // The ack is withheld while the slot is full, which keeps the adder
        // holding its result as backpressure.
        if (add_ready && slot_free) begin
          sum_nxt   = add_result;
          valid_nxt = 1'b1;
          ack_nxt   = 1'b1;
        end
      end
      ST_RELEASE: begin
        load_nxt = 1'b0;
      end
      default: begin
        load_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      add_load  <= 1'b0;
      add_ack   <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      out_sum   <= '0;
      out_valid <= 1'b0;
    end else begin
      add_load  <= load_nxt;
      add_ack   <= ack_nxt;
      add_a     <= a_nxt;
      add_b     <= b_nxt;
      out_sum   <= sum_nxt;
      out_valid <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// tb/tb_fp_add_sequencer.sv - directed self-checking bench for fp_add_sequencer
module tb_fp_add_sequencer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_a = '0;
  logic [31:0]   in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_sum;
  logic          add_load;
  logic [31:0]   add_a;
  logic [31:0]   add_b;
  logic [31:0]   add_result;
  logic          add_ready;
  logic          add_ack;
  logic [CW-1:0] fifo_count;
  logic          busy;

  int checks = 0;
  int errors = 0;

  fp_add_sequencer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .add_load   (add_load),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_result (add_result),
    .add_ready  (add_ready),
    .add_ack    (add_ack),
    .fifo_count (fifo_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Behavioural adder: ready model_n cycles after load, holds until ack,
  // optionally keeps ready high model_hold cycles after the ack.
  int         model_n    = 3;
  int         model_hold = 0;
  logic [2:0] m_phase;
  int         m_cnt;

  function automatic logic [31:0] model_sum(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4144CCCD && b == 32'h4165851F) return 32'h41D528F6;
    return a + b;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      add_ready  <= 1'b0;
      add_result <= '0;
      m_phase    <= 3'd0;
      m_cnt      <= 0;
    end else begin
      case (m_phase)
        3'd0: if (add_load) begin m_phase <= 3'd1; m_cnt <= 1; end
        3'd1: begin
          if (m_cnt >= model_n) begin
            add_ready  <= 1'b1;
            add_result <= model_sum(add_a, add_b);
            m_phase    <= 3'd2;
          end else m_cnt <= m_cnt + 1;
        end
        3'd2: if (add_ack) begin
          if (model_hold == 0) begin add_ready <= 1'b0; m_phase <= 3'd3; end
          else begin m_cnt <= model_hold; m_phase <= 3'd4; end
        end
        3'd4: begin
          if (m_cnt <= 1) begin add_ready <= 1'b0; m_phase <= 3'd3; end
          else m_cnt <= m_cnt - 1;
        end
        default: if (!add_load) m_phase <= 3'd0;
      endcase
    end
  end

  int   ack_cnt   = 0;
  int   load_rise = 0;
  logic prev_load = 1'b0;
  always @(posedge clk) begin
    if (add_ack) ack_cnt <= ack_cnt + 1;
    if (add_load && !prev_load) load_rise <= load_rise + 1;
    prev_load <= add_load;
  end

  logic [31:0] exp_q [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int bound);
    int n = 0;
    while (!out_valid && n < bound) begin step(); n++; end
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic collect(input string tag, input int bound);
    int n = 0;
    while (exp_q.size() > 0 && n < bound) begin
      if (out_valid) chk(tag, out_sum, exp_q.pop_front());
      step();
      n++;
    end
    chk({tag, " drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   acks_before, loads_before;
    logic seen, fell;

    // Reset values
    step(); step();
    chk("rst in_ready",   32'(in_ready),   32'd1);
    chk("rst out_valid",  32'(out_valid),  32'd0);
    chk("rst out_sum",    out_sum,         32'd0);
    chk("rst add_load",   32'(add_load),   32'd0);
    chk("rst add_a",      add_a,           32'd0);
    chk("rst add_b",      add_b,           32'd0);
    chk("rst add_ack",    32'(add_ack),    32'd0);
    chk("rst fifo_count", 32'(fifo_count), 32'd0);
    chk("rst busy",       32'(busy),       32'd0);
    reset = 1'b1;
    step();

    // 1: single pair, latency and handshake
    push(32'h4144CCCD, 32'h4165851F);
    chk("t1 count after push", 32'(fifo_count), 32'd1);
    chk("t1 load not yet",     32'(add_load),   32'd0);
    step();
    chk("t1 load",  32'(add_load), 32'd1);
    chk("t1 add_a", add_a, 32'h4144CCCD);
    chk("t1 add_b", add_b, 32'h4165851F);
    chk("t1 busy",  32'(busy), 32'd1);
    acks_before = ack_cnt;
    wait_valid("t1", 30);
    chk("t1 ack with valid", 32'(add_ack), 32'd1);
    chk("t1 out_sum", out_sum, 32'h41D528F6);
    step();
    chk("t1 ack pulse", 32'(add_ack), 32'd0);
    step(); step();
    chk("t1 one ack", 32'(ack_cnt - acks_before), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t1 consumed", 32'(out_valid), 32'd0);
    step(); step();

    // 2: five pairs back-to-back into a 4-deep FIFO, out_ready held low
    for (int k = 1; k <= 5; k++) begin
      in_valid = 1'b1;
      in_a     = 32'(k);
      in_b     = 32'h10000000;
      step();
    end
    chk("t2 full count",  32'(fifo_count), 32'd4);
    chk("t2 in_ready low", 32'(in_ready),  32'd0);
    in_a = 32'd6;
    step();
    in_valid = 1'b0;
    chk("t2 no overwrite", 32'(fifo_count), 32'd4);
    exp_q = '{32'h10000001, 32'h10000002, 32'h10000003, 32'h10000004, 32'h10000005};
    out_ready = 1'b1;
    collect("t2 result", 300);
    out_ready = 1'b0;
    repeat (4) step();
    chk("t2 no extra result", 32'(out_valid), 32'd0);
    chk("t2 idle",            32'(busy),      32'd0);

    // 3: backpressure holds the ack while the adder is ready
    push(32'h20000000, 32'h00000001);
    wait_valid("t3 first", 30);
    chk("t3 first sum", out_sum, 32'h20000001);
    push(32'h30000000, 32'h00000002);
    repeat (12) step();
    chk("t3 model ready",    32'(add_ready), 32'd1);
    chk("t3 load held",      32'(add_load),  32'd1);
    chk("t3 ack withheld",   32'(add_ack),   32'd0);
    chk("t3 out_sum stable", out_sum, 32'h20000001);
    out_ready = 1'b1;
    step();
    chk("t3 ack fires",   32'(add_ack),   32'd1);
    chk("t3 refill sum",  out_sum,        32'h30000002);
    chk("t3 refill valid", 32'(out_valid), 32'd1);
    step();
    out_ready = 1'b0;
    chk("t3 drained", 32'(out_valid), 32'd0);
    repeat (4) step();

    // 4: asynchronous reset in the middle of a transaction
    in_valid = 1'b1; in_a = 32'hB1B00000; in_b = 32'hB8200000;
    step();
    in_a = 32'h3F800000; in_b = 32'h3F800000;
    step();
    in_valid = 1'b0;
    chk("t4 load",  32'(add_load),   32'd1);
    chk("t4 add_a", add_a,           32'hB1B00000);
    chk("t4 queued", 32'(fifo_count), 32'd1);
    step();
    #2 reset = 1'b0;
    #1;
    chk("t4 async load",  32'(add_load),   32'd0);
    chk("t4 async ack",   32'(add_ack),    32'd0);
    chk("t4 async add_a", add_a,           32'd0);
    chk("t4 async add_b", add_b,           32'd0);
    chk("t4 async count", 32'(fifo_count), 32'd0);
    chk("t4 async ready", 32'(in_ready),   32'd1);
    chk("t4 async busy",  32'(busy),       32'd0);
    chk("t4 async valid", 32'(out_valid),  32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    acks_before  = ack_cnt;
    loads_before = load_rise;
    out_ready    = 1'b1;
    seen         = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      seen = seen | out_valid;
    end
    out_ready = 1'b0;
    chk("t4 no stale result", 32'(seen), 32'd0);
    chk("t4 no stale ack",    32'(ack_cnt - acks_before),    32'd0);
    chk("t4 no stale load",   32'(load_rise - loads_before), 32'd0);

    // 5: adder keeps ready high after the ack; next issue waits for it to fall
    model_hold = 2;
    in_valid = 1'b1; in_a = 32'h40000000; in_b = 32'h00000003;
    step();
    in_a = 32'h50000000; in_b = 32'h00000004;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!add_ack && n < 40) begin step(); n++; end
    chk("t5 first ack", 32'(add_ack), 32'd1);
    step();
    chk("t5 ready held", 32'(add_ready), 32'd1);
    fell = 1'b0;
    n = 0;
    while (!add_load && n < 20) begin
      if (!add_ready) fell = 1'b1;
      step();
      n++;
    end
    chk("t5 reissue",         32'(add_load), 32'd1);
    chk("t5 ready fell first", 32'(fell),    32'd1);
    chk("t5 second add_a",    add_a,         32'h50000000);
    model_hold = 0;
    exp_q = '{32'h40000003, 32'h50000004};
    out_ready = 1'b1;
    collect("t5 result", 100);
    out_ready = 1'b0;
    repeat (4) step();

    // 6: pair with a -0 operand
    loads_before = load_rise;
    push(32'h80000000, 32'h65B1C000);
    wait_valid("t6", 30);
`ifdef FP_SEQ_ZERO_BYPASS_EN
    chk("t6 bypass sum",   out_sum, 32'h65B1C000);
    chk("t6 no adder load", 32'(load_rise - loads_before), 32'd0);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    push(32'h80000000, 32'h80000000);
    wait_valid("t6 both neg", 30);
    chk("t6 -0 + -0", out_sum, 32'h80000000);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    push(32'h80000000, 32'h00000000);
    wait_valid("t6 mixed", 30);
    chk("t6 -0 + +0", out_sum, 32'h00000000);
    chk("t6 still no load", 32'(load_rise - loads_before), 32'd0);
`else
    chk("t6 adder sum",  out_sum, 32'hE5B1C000);
    chk("t6 adder used", 32'(load_rise - loads_before), 32'd1);
`endif
    out_ready = 1'b1; step(); out_ready = 1'b0;
    repeat (4) step();
    chk("t6 idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
